// File: rtl/flu_wb_arbiter.sv
// ---------------------------------------------------------------------------
// flu_wb_arbiter
//
// Purpose:
//   Shares the single fixed-latency-unit scoreboard write-back port among
//   several multi-cycle result producers (multiplier, divider, FPU). Each
//   producer owns a small FIFO. A round-robin arbiter chooses one FIFO head
//   per cycle. While the scoreboard back-pressures, the choice is frozen so
//   the presented result never changes under the consumer.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   flush_i      discard every buffered result (round-robin pointer kept)
//   src_valid_i  per-source result valid
//   src_ready_o  per-source FIFO not full (registered state only)
//   src_data_i   packed results, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   src_id_i     packed transaction ids, packed the same way
//   src_ex_i     per-source exception flag
//   wb_valid_o   write-back valid (any FIFO non-empty)
//   wb_ready_i   scoreboard accepts the write-back
//   wb_data_o    granted result (0 when idle)
//   wb_id_o      granted transaction id (0 when idle)
//   wb_ex_o      granted exception flag (0 when idle)
//   wb_src_o     index of the granted source (0 when idle)
//   busy_o       any FIFO non-empty
// ---------------------------------------------------------------------------
module flu_wb_arbiter #(
  parameter int NR_SRC     = 3,
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 3,
  localparam int SRC_W     = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NR_SRC-1:0]            src_valid_i,
  output logic [NR_SRC-1:0]            src_ready_o,
  input  logic [NR_SRC*DATA_WIDTH-1:0] src_data_i,
  input  logic [NR_SRC*ID_WIDTH-1:0]   src_id_i,
  input  logic [NR_SRC-1:0]            src_ex_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [DATA_WIDTH-1:0]        wb_data_o,
  output logic [ID_WIDTH-1:0]          wb_id_o,
  output logic                         wb_ex_o,
  output logic [SRC_W-1:0]             wb_src_o,
  output logic                         busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + ID_WIDTH + 1;

  // Entry layout is {data, id, ex}.
  logic [ENT_W-1:0] r_mem   [NR_SRC][DEPTH];
  logic [PTR_W-1:0] r_wrPtr [NR_SRC];
  logic [PTR_W-1:0] r_rdPtr [NR_SRC];
  logic [CNT_W-1:0] r_count [NR_SRC];

  logic [SRC_W-1:0] r_rr;
  logic [SRC_W-1:0] r_heldIdx;
  logic             r_hold;

  logic [NR_SRC-1:0] w_notEmpty;
  logic [NR_SRC-1:0] w_push;
  logic [NR_SRC-1:0] w_pop;
  logic [SRC_W-1:0]  w_grant;
  logic [SRC_W-1:0]  w_rrNext;
  logic              w_any;
  logic              w_accept;
  logic [ENT_W-1:0]  w_head;

  // Full/empty come from the counts, never from pointer equality, so a
  // completely full FIFO with wrapped pointers is still told apart from empty.
  always_comb begin
    w_notEmpty  = '0;
    src_ready_o = '0;
    for (int k = 0; k < NR_SRC; k++) begin
      w_notEmpty[k]  = (r_count[k] != '0);
      src_ready_o[k] = (r_count[k] != CNT_W'(DEPTH));
    end
  end

  assign w_any  = |w_notEmpty;
  assign busy_o = w_any;

  // Grant selection: a held index wins outright; otherwise scan from the
  // round-robin pointer and take the first non-empty FIFO, wrapping around.
  always_comb begin
    logic found;
    int   idx;
    w_grant = '0;
    found   = 1'b0;
    idx     = 0;
    if (r_hold) begin
      w_grant = r_heldIdx;
    end else begin
      for (int i = 0; i < NR_SRC; i++) begin
        idx = int'(r_rr) + i;
        if (idx >= NR_SRC) idx = idx - NR_SRC;
        if (!found && w_notEmpty[idx]) begin
          w_grant = SRC_W'(idx);
          found   = 1'b1;
        end
      end
    end
  end

  assign w_head   = r_mem[w_grant][r_rdPtr[w_grant]];
  assign w_accept = w_any & wb_ready_i & ~flush_i;
  assign w_rrNext = (w_grant == SRC_W'(NR_SRC - 1)) ? '0 : w_grant + SRC_W'(1);

  // Output fields are forced to zero whenever nothing is buffered so the
  // scoreboard never sees stale FIFO contents.
  always_comb begin
    wb_valid_o = w_any;
    wb_data_o  = '0;
    wb_id_o    = '0;
    wb_ex_o    = 1'b0;
    wb_src_o   = '0;
    if (w_any) begin
      {wb_data_o, wb_id_o, wb_ex_o} = w_head;
      wb_src_o                      = w_grant;
    end
  end

  // Flush suppresses both the write and the pop so that nothing is half
  // committed on the flushing edge.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int k = 0; k < NR_SRC; k++) begin
      w_push[k] = src_valid_i[k] & src_ready_o[k] & ~flush_i;
      w_pop[k]  = w_accept & (w_grant == SRC_W'(k));
    end
  end

  // FIFO bookkeeping; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int k = 0; k < NR_SRC; k++) begin
        r_count[k] <= '0;
        r_wrPtr[k] <= '0;
        r_rdPtr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NR_SRC; k++) begin
        if (w_push[k]) r_wrPtr[k] <= r_wrPtr[k] + PTR_W'(1);
        if (w_pop[k])  r_rdPtr[k] <= r_rdPtr[k] + PTR_W'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CNT_W'(1);
          2'b01:   r_count[k] <= r_count[k] - CNT_W'(1);
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // Storage needs no reset: a slot is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_SRC; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wrPtr[k]] <= {src_data_i[k*DATA_WIDTH +: DATA_WIDTH],
                                 src_id_i[k*ID_WIDTH +: ID_WIDTH],
                                 src_ex_i[k]};
      end
    end
  end

  // Arbitration state: the pointer advances past the source just accepted,
  // and a stalled grant is latched so later arrivals cannot pre-empt it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr      <= '0;
      r_hold    <= 1'b0;
      r_heldIdx <= '0;
    end else if (flush_i) begin
      r_hold    <= 1'b0;
    end else if (w_accept) begin
      r_hold    <= 1'b0;
      r_rr      <= w_rrNext;
    end else if (w_any) begin
      r_hold    <= 1'b1;
      r_heldIdx <= w_grant;
    end
  end

endmodule

// File: doc/flu_wb_arbiter.md
Name: flu_wb_arbiter

Overview:
- Shares the single fixed-latency-unit scoreboard write-back port among several multi-cycle result producers (multiplier, divider, FPU).
- Each producer pushes results into its own small FIFO. A round-robin arbiter selects one FIFO head per cycle for write-back.
- The arbiter holds its selection stable while the scoreboard back-pressures.
- It sits in the execute stage, between the producers and the scoreboard write port.

Parameters:
- NR_SRC, 3, number of result producers (2..8)
- DEPTH, 2, entries per source FIFO (power of two, >=2)
- DATA_WIDTH, 64, result width
- ID_WIDTH, 3, scoreboard transaction-id width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered results
- src_valid_i  in  NR_SRC  per-source result valid
- src_ready_o  out  NR_SRC  per-source FIFO not full
- src_data_i  in  NR_SRC*DATA_WIDTH  packed results; source k occupies [k*DATA_WIDTH +: DATA_WIDTH]
- src_id_i  in  NR_SRC*ID_WIDTH  packed trans ids, packed the same way
- src_ex_i  in  NR_SRC  per-source exception flag
- wb_valid_o  out  1  write-back valid
- wb_ready_i  in  1  scoreboard accepts write-back
- wb_data_o  out  DATA_WIDTH  selected result
- wb_id_o  out  ID_WIDTH  selected trans id
- wb_ex_o  out  1  selected exception flag
- wb_src_o  out  $clog2(NR_SRC)  index of the granted source
- busy_o  out  1  any FIFO non-empty

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - all FIFO counts and read/write pointers go to 0; round-robin pointer rr goes to 0; hold flag goes to 0.
  - outputs after reset: wb_valid_o=0, wb_data_o=0, wb_id_o=0, wb_ex_o=0, wb_src_o=0, busy_o=0, src_ready_o=all 1.
  - Reset mid-operation drops all buffered entries without emitting them.
- Push:
  - Source k writes {data, id, ex} at the edge when src_valid_i[k] & src_ready_o[k].
  - src_ready_o[k] = (count_k != DEPTH). It depends only on registered state; a same-cycle pop never raises ready.
  - src_valid_i[k] while src_ready_o[k]=0 is ignored; the producer must hold it.
- Latency: a push at edge t is visible on wb_* in the cycle after edge t at the earliest. There is no bypass from src_*_i to wb_*.
- Arbitration (combinational from FIFO heads):
  - If hold=1, the grant is the held index.
  - Otherwise the grant is the first non-empty FIFO scanning rr, rr+1, ... modulo NR_SRC.
  - wb_valid_o = any FIFO non-empty.
  - wb_data_o, wb_id_o, wb_ex_o and wb_src_o come from the granted head; all are 0 when wb_valid_o=0.
- Pop: at the edge when wb_valid_o & wb_ready_i, the granted FIFO pops, rr becomes (grant+1) mod NR_SRC, and hold clears.
- Back-pressure:
  - If wb_valid_o & !wb_ready_i, hold is set and the held index is registered.
  - wb_data_o, wb_id_o, wb_ex_o and wb_src_o stay stable until acceptance, even if a higher-priority FIFO becomes non-empty.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance.
- Pointer wrap-around: pointers wrap modulo DEPTH. Full and empty are derived from the count, not from pointer equality.
- Flush:
  - flush_i at an edge clears all counts, pointers and hold; rr is unchanged.
  - Flush wins over a same-cycle push and a same-cycle pop; no entry is written or popped.
  - wb_valid_o=0 in the cycle after the flush.
- Fairness: with all sources continuously non-empty and wb_ready_i=1, grants rotate 0,1,..,NR_SRC-1. No source waits more than NR_SRC-1 accepted write-backs.
- busy_o = OR of (count_k != 0).

Test Plan:
- Reset then push: pulse src_valid_i=3'b010 with data 64'hA5, id 3 -> next cycle wb_valid_o=1, wb_src_o=1, wb_data_o=64'hA5, wb_id_o=3; with wb_ready_i=1 -> following cycle wb_valid_o=0, busy_o=0.
- Round-robin: fill all 3 FIFOs with 2 entries each, wb_ready_i=1 -> wb_src_o sequence 0,1,2,0,1,2; 6 accepts then wb_valid_o=0.
- Back-pressure hold: FIFO 2 holds one entry, wb_ready_i=0, then push into source 0 -> wb_src_o stays 2 with unchanged data; raise wb_ready_i -> source 2 accepted, then source 0 granted.
- Full FIFO: push 2 entries into source 1 with wb_ready_i=0 -> src_ready_o[1]=0. A third valid is held, not written. Pop one -> src_ready_o[1]=1 next cycle; the held third entry is later emitted in order.
- Flush with concurrent push: FIFOs hold 3 entries; assert flush_i together with src_valid_i[0] -> next cycle wb_valid_o=0, busy_o=0, src_ready_o=3'b111; the flushed push never appears.
- Sync reset mid-stream: rst_i=1 for one cycle while wb_valid_o=1 -> next cycle all outputs are at their reset values; the next grant search starts at index 0.
